mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sequences a single-ported 32-bit word memory between two requesters: the instruction fetch stage and the load/store (data) stage of the Thumb emulator core.
- Fetch requests use a byte PC and return a 16-bit halfword.
- Data requests use a word index and read or write 32 bits.
- A fixed-latency memory is driven with registered strobes.
- Arbitration gives data priority, with a starvation limit that guarantees fetch progress.

Parameters:
ADDR_W, 10, memory word-address width (1024 words).
MEM_LAT, 1, cycles from the edge sampling mem_en=1 to mem_rdata valid; legal range 1..4.
STARVE_MAX, 3, maximum consecutive contested data grants before fetch is forced.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
if_req  in  1  fetch request; held with if_addr until if_ack.
if_addr  in  32  fetch byte address (PC); bit0 ignored.
if_ack  out  1  one-cycle fetch completion pulse.
if_data  out  16  fetched halfword; valid while if_ack=1, held afterwards.
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack.
d_we  in  1  1 = store, 0 = load.
d_addr  in  ADDR_W  data word index.
d_wdata  in  32  store data.
d_ack  out  1  one-cycle data completion pulse.
d_rdata  out  32  load data; valid while d_ack=1, held afterwards.
mem_en  out  1  memory access strobe, one cycle per access.
mem_we  out  1  memory write enable, qualified by mem_en.
mem_addr  out  ADDR_W  memory word address.
mem_wdata  out  32  memory write data.
mem_rdata  in  32  memory read data.
busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered.
- Reset (async, active-high) forces state=IDLE, starve_cnt=0, and all outputs to 0 immediately, including if_data and d_rdata.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: on an edge with any req high, run arbitration, then latch the grantee, address, we, wdata and halfword select; go to ACCESS. With no req, stay in IDLE.
- ACCESS (1 cycle):
  - Outputs: mem_en=1; mem_we = d_we if data is granted, else 0; mem_addr and mem_wdata from the latched values.
  - Next state: WAIT with lat_cnt=MEM_LAT.
- WAIT:
  - Outputs: mem_en=0.
  - Each edge decrements lat_cnt.
  - On the edge where lat_cnt==1: capture mem_rdata (reads only) and go to DONE.
- DONE (1 cycle):
  - Outputs: the grantee's ack=1. For fetch, if_data = sel ? rdata[31:16] : rdata[15:0]. For a data load, d_rdata = rdata. For a data store, d_rdata is unchanged.
  - Next state: on the exit edge, if any req is high, arbitrate and go directly to ACCESS (no IDLE bubble); otherwise go to IDLE.
- Latency: ack is high during the cycle after edge MEM_LAT+1, counting edge 0 as the edge that sampled req. Throughput is one access per MEM_LAT+2 cycles.
- Handshake: the requester keeps req and its qualifiers stable until ack. During the ack cycle it either deasserts req or presents a new request, which is sampled at the DONE exit edge.
- Fetch address: mem_addr = if_addr[ADDR_W+1:2]; sel = if_addr[1]. Upper bits are ignored, so addresses wrap.
- Arbitration:
  - Only one req high: that requester is granted.
  - Both high: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
  - starve_cnt increments, saturating at STARVE_MAX, on each data grant made while if_req=1.
  - starve_cnt clears on any fetch grant.
  - An uncontested data grant leaves starve_cnt unchanged.
- Acks never overlap; if_ack and d_ack are never both high.
- Reset mid-operation: the access is abandoned and no ack is issued. A store already strobed in ACCESS may have completed in memory.
- mem_en is high for exactly one cycle per grant.

Test Plan:
1. Reset → assert reset for 3 cycles with both reqs high → all outputs 0, busy=0, mem_en never high; release reset → first grant is data.
2. Halfword fetch, MEM_LAT=1, mem[5]=0x1234ABCD:
   - if_addr=0x16 → mem_addr=5, mem_en one cycle, if_ack in the 3rd cycle after req is sampled, if_data=0x1234.
   - if_addr=0x14 → if_data=0xABCD.
3. Data store then load, MEM_LAT=2:
   - d_we=1, d_addr=0x3F, d_wdata=0xDEADBEEF → mem_we=1 with mem_en, d_ack after 4 cycles, d_rdata unchanged.
   - Load from 0x3F → d_rdata=0xDEADBEEF.
4. Contention, STARVE_MAX=3, both reqs held continuously → grant order D,D,D,F,D,D,D,F; no ack overlap.
5. MEM_LAT=3, fetch in WAIT with lat_cnt=2, assert reset → if_ack never pulses, state=IDLE, busy=0 asynchronously; next fetch completes normally.
6. Back-to-back: d_req held high across d_ack with a new d_addr → mem_en reasserts in the cycle immediately after DONE (period MEM_LAT+2), busy stays high throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported 32-bit word memory between the
// instruction fetch stage (byte PC, halfword result) and the load/store stage
// (word index, 32-bit read/write). Data has priority; a saturating starvation
// counter forces a fetch grant after STARVE_MAX contested data grants.
// Every access takes ACCESS + MEM_LAT x WAIT + DONE cycles, and a new request
// sampled on the DONE exit edge goes straight to ACCESS.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [15:0]       if_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t          state;
  logic [2:0]      lat_cnt;
  logic [SW-1:0]   starve_cnt;
  logic            grant_d;   // 1 = data owns the current access
  logic            sel;       // fetch halfword select (if_addr[1])
  logic            any_req;
  logic            pick_d;

  // Arbitration: data wins unless fetch is also waiting and has been starved.
  always_comb begin
    any_req = if_req | d_req;
    pick_d  = d_req && !(if_req && (starve_cnt == SMAX));
  end

  // Access sequencer: grant/latch, strobe memory, count latency, acknowledge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      grant_d    <= 1'b0;
      sel        <= 1'b0;
      if_ack     <= 1'b0;
      if_data    <= '0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      mem_en <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (any_req) begin
            state   <= ACCESS;
            busy    <= 1'b1;
            mem_en  <= 1'b1;
            grant_d <= pick_d;
            if (pick_d) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              // only a data grant that made fetch wait counts as starvation
              if (if_req && (starve_cnt != SMAX))
                starve_cnt <= starve_cnt + SW'(1);
            end else begin
              mem_we     <= 1'b0;
              mem_addr   <= if_addr[ADDR_W+1:2];
              mem_wdata  <= '0;
              sel        <= if_addr[1];
              starve_cnt <= '0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ACCESS: begin
          state   <= WAIT;
          lat_cnt <= 3'(MEM_LAT);
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            state <= DONE;
            if (grant_d) begin
              d_ack <= 1'b1;
              // stores leave the last load result visible
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              if_ack  <= 1'b1;
              if_data <= sel ? mem_rdata[31:16] : mem_rdata[15:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: fixed-latency memory model plus a
// transaction-level reference (word array, starvation count, expected
// latency) driving directed and randomized request streams.
module tb_mem_port_arbiter;
  localparam int AW  = 10;
  localparam int LAT = 3;
  localparam int SM  = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_ack;
  logic [15:0]   if_data;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ack;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;
  logic          mem_init;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [31:0] seed_word(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  // Memory: sampled on the mem_en edge, data emerges LAT edges later.
  logic [31:0] mem [1024];
  logic [31:0] rd_pipe [LAT];
  assign mem_rdata = rd_pipe[LAT-1];
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= seed_word(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      rd_pipe[0] <= mem[mem_addr];
    end
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference state
  logic [31:0] ref_mem [1024];
  logic [31:0] ref_drdata;
  int          ref_starve;

  function automatic bit arb_data(bit f, bit d);
    return d && !(f && ref_starve == SM);
  endfunction

  task automatic model_grant(bit f, bit gd);
    if (gd) begin
      if (f && ref_starve < SM) ref_starve++;
    end else ref_starve = 0;
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    ref_starve = 0;
    ref_drdata = '0;
  endtask

  // Runs until an ack is seen (bounded); reports latency and strobe activity.
  task automatic wait_ack(output int k, output logic [1:0] acks,
                          output int en_cnt, output int en_at,
                          output logic [AW-1:0] en_addr, output logic en_we,
                          output logic [31:0] en_wdata, output int idle_cyc);
    k = -1; acks = '0; en_cnt = 0; en_at = -1; en_addr = '0; en_we = 1'b0;
    en_wdata = '0; idle_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (mem_en) begin
        en_cnt++;
        if (en_at < 0) en_at = c;
        en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
      end
      if (!busy) idle_cyc++;
      if (if_ack || d_ack) begin
        k = c; acks = {if_ack, d_ack};
        return;
      end
    end
  endtask

  int k, en_cnt, en_at, idle_cyc;
  logic [1:0] acks;
  logic [AW-1:0] en_addr;
  logic en_we;
  logic [31:0] en_wdata;

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    d_addr = 10'd7; if_addr = 32'h40; d_wdata = 32'h1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({if_ack, d_ack, mem_en, mem_we, busy, if_data, d_rdata, mem_addr, mem_wdata} !== '0) begin
        n_bad++;
        $display("FAIL reset_outs cyc%0d: got en=%b busy=%b ack=%b%b if_data=%h d_rdata=%h want all 0",
                 i, mem_en, busy, if_ack, d_ack, if_data, d_rdata);
      end
    end
    reset = 1'b0; ref_starve = 0; ref_drdata = '0;
    wait_ack(k, acks, en_cnt, en_at, en_addr, en_we, en_wdata, idle_cyc);
    if_req = 1'b0; d_req = 1'b0;
    n_cmp++;
    if ({acks, 8'(k), 4'(en_cnt), en_addr} !== {2'b01, 8'(LAT+2), 4'd1, 10'd7}) begin
      n_bad++;
      $display("FAIL reset_first_grant: got ack=%b k=%0d en=%0d addr=%0d want ack=01 k=%0d en=1 addr=7",
               acks, k, en_cnt, en_addr, LAT+2);
    end
    n_cmp++;
    if (d_rdata !== ref_mem[7]) begin
      n_bad++;
      $display("FAIL reset_first_load: got %h want %h", d_rdata, ref_mem[7]);
    end
    repeat (2) tick();
  endtask

  task automatic test_fetch();
    logic [31:0] a;
    logic [AW-1:0] w;
    logic [15:0] exp;
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd5; d_wdata = 32'h1234ABCD;
    wait_ack(k, acks, en_cnt, en_at, en_addr, en_we, en_wdata, idle_cyc);
    d_req = 1'b0; ref_mem[5] = 32'h1234ABCD;
    n_cmp++;
    if (acks !== 2'b01) begin
      n_bad++; $display("FAIL fetch_setup_store: got ack=%b want 01", acks);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      a = (i == 0) ? 32'h16 : (i == 1) ? 32'h14 : $urandom;
      w = a[AW+1:2];
      exp = a[1] ? ref_mem[w][31:16] : ref_mem[w][15:0];
      if_req = 1'b1; if_addr = a;
      wait_ack(k, acks, en_cnt, en_at, en_addr, en_we, en_wdata, idle_cyc);
      if_req = 1'b0;
      n_cmp++;
      if ({acks, 8'(k), 4'(en_cnt), 8'(en_at), en_addr, en_we} !== {2'b10, 8'(LAT+2), 4'd1, 8'd1, w, 1'b0}) begin
        n_bad++;
        $display("FAIL fetch_timing a=%h: got ack=%b k=%0d en=%0d at=%0d addr=%0d we=%b want ack=10 k=%0d en=1 at=1 addr=%0d we=0",
                 a, acks, k, en_cnt, en_at, en_addr, en_we, LAT+2, w);
      end
      n_cmp++;
      if (if_data !== exp) begin
        n_bad++; $display("FAIL fetch_data a=%h: got %h want %h", a, if_data, exp);
      end
      tick();
      n_cmp++;
      if (if_data !== exp || if_ack !== 1'b0) begin
        n_bad++; $display("FAIL fetch_hold a=%h: got %h ack=%b want %h ack=0", a, if_data, if_ack, exp);
      end
    end
  endtask

  task automatic test_store_load();
    logic [AW-1:0] a;
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 10'h3F : 10'($urandom);
      v = (i == 0) ? 32'hDEADBEEF : $urandom;
      d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = v;
      wait_ack(k, acks, en_cnt, en_at, en_addr, en_we, en_wdata, idle_cyc);
      d_req = 1'b0; ref_mem[a] = v;
      n_cmp++;
      if ({acks, 8'(k), 4'(en_cnt), en_addr, en_we, en_wdata} !== {2'b01, 8'(LAT+2), 4'd1, a, 1'b1, v}) begin
        n_bad++;
        $display("FAIL store_strobe a=%0d: got ack=%b k=%0d en=%0d addr=%0d we=%b wd=%h want ack=01 k=%0d en=1 addr=%0d we=1 wd=%h",
                 a, acks, k, en_cnt, en_addr, en_we, en_wdata, LAT+2, a, v);
      end
      n_cmp++;
      if (d_rdata !== ref_drdata) begin
        n_bad++; $display("FAIL store_keeps_rdata: got %h want %h", d_rdata, ref_drdata);
      end
      tick();
      if (i % 2 == 1) a = 10'($urandom);  // sometimes read an untouched word
      d_req = 1'b1; d_we = 1'b0; d_addr = a;
      wait_ack(k, acks, en_cnt, en_at, en_addr, en_we, en_wdata, idle_cyc);
      d_req = 1'b0; ref_drdata = ref_mem[a];
      n_cmp++;
      if ({acks, 8'(k), en_we} !== {2'b01, 8'(LAT+2), 1'b0} || d_rdata !== ref_drdata) begin
        n_bad++;
        $display("FAIL load a=%0d: got ack=%b k=%0d we=%b data=%h want ack=01 k=%0d we=0 data=%h",
                 a, acks, k, en_we, d_rdata, LAT+2, ref_drdata);
      end
      tick();
    end
  endtask

  task automatic test_contention();
    bit gd;
    logic [AW-1:0] w;
    string got_s, want_s;
    do_reset();
    got_s = ""; want_s = "";
    if_req = 1'b1; if_addr = $urandom; d_req = 1'b1; d_we = 1'b0; d_addr = 10'($urandom);
    for (int g = 0; g < 8; g++) begin
      gd = arb_data(1'b1, 1'b1);
      model_grant(1'b1, gd);
      want_s = {want_s, gd ? "D" : "F"};
      wait_ack(k, acks, en_cnt, en_at, en_addr, en_we, en_wdata, idle_cyc);
      got_s = {got_s, (acks == 2'b01) ? "D" : (acks == 2'b10) ? "F" : "X"};
      n_cmp++;
      if (k !== LAT+2 || idle_cyc !== 0) begin
        n_bad++; $display("FAIL contention_period g=%0d: got k=%0d idle=%0d want k=%0d idle=0", g, k, idle_cyc, LAT+2);
      end
      w = if_addr[AW+1:2];
      n_cmp++;
      if (gd ? (d_rdata !== ref_mem[d_addr]) : (if_data !== (if_addr[1] ? ref_mem[w][31:16] : ref_mem[w][15:0]))) begin
        n_bad++; $display("FAIL contention_data g=%0d: got d=%h if=%h", g, d_rdata, if_data);
      end
      if (gd) d_addr = 10'($urandom); else if_addr = $urandom;
    end
    if_req = 1'b0; d_req = 1'b0;
    n_cmp++;
    if (got_s != want_s || want_s != "DDDFDDDF") begin
      n_bad++; $display("FAIL contention_order: got %s want DDDFDDDF", got_s);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_midop();
    logic [31:0] a;
    logic [AW-1:0] w;
    int seen;
    do_reset();
    a = $urandom;
    if_req = 1'b1; if_addr = a;
    repeat (3) tick();   // ACCESS, WAIT(LAT), WAIT(LAT-1)
    n_cmp++;
    if (busy !== 1'b1 || if_ack !== 1'b0) begin
      n_bad++; $display("FAIL midop_pre: got busy=%b ack=%b want busy=1 ack=0", busy, if_ack);
    end
    reset = 1'b1; if_req = 1'b0;
    #1;
    n_cmp++;
    if ({busy, mem_en, if_ack, d_ack} !== 4'b0) begin
      n_bad++; $display("FAIL midop_async: got busy=%b en=%b ack=%b%b want all 0", busy, mem_en, if_ack, d_ack);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) reset = 1'b0;
      if (if_ack || d_ack || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL midop_no_ack: got %0d active cycles want 0", seen);
    end
    ref_starve = 0;
    w = a[AW+1:2];
    if_req = 1'b1;
    wait_ack(k, acks, en_cnt, en_at, en_addr, en_we, en_wdata, idle_cyc);
    if_req = 1'b0;
    n_cmp++;
    if ({acks, 8'(k), en_addr} !== {2'b10, 8'(LAT+2), w} || if_data !== (a[1] ? ref_mem[w][31:16] : ref_mem[w][15:0])) begin
      n_bad++; $display("FAIL midop_recover: got ack=%b k=%0d addr=%0d data=%h", acks, k, en_addr, if_data);
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [31:0] v;
    do_reset();
    a = 10'($urandom); v = $urandom;
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = v;
    for (int i = 0; i < 5; i++) begin
      wait_ack(k, acks, en_cnt, en_at, en_addr, en_we, en_wdata, idle_cyc);
      n_cmp++;
      if ({acks, 8'(k), 4'(en_cnt), 8'(en_at), 8'(idle_cyc), en_addr} !== {2'b01, 8'(LAT+2), 4'd1, 8'd1, 8'd0, a}) begin
        n_bad++;
        $display("FAIL b2b i=%0d: got ack=%b k=%0d en=%0d at=%0d idle=%0d addr=%0d want ack=01 k=%0d en=1 at=1 idle=0 addr=%0d",
                 i, acks, k, en_cnt, en_at, idle_cyc, en_addr, LAT+2, a);
      end
      if (d_we) ref_mem[a] = v;
      else ref_drdata = ref_mem[a];
      n_cmp++;
      if (d_rdata !== ref_drdata) begin
        n_bad++; $display("FAIL b2b_rdata i=%0d: got %h want %h", i, d_rdata, ref_drdata);
      end
      d_we = (i % 2 == 0) ? 1'b0 : 1'b1;
      if (d_we) a = 10'($urandom);  // loads re-read the word just written
      v = $urandom;
      d_addr = a; d_wdata = v;
    end
    d_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    bit pf, pd, gd;
    logic [AW-1:0] w;
    logic [15:0] exp_h;
    do_reset();
    pf = 0; pd = 0;
    for (int t = 0; t < 40; t++) begin
      if (!pf && $urandom_range(1, 0) == 1) begin pf = 1; if_addr = $urandom; end
      if (!pd && $urandom_range(1, 0) == 1) begin
        pd = 1; d_we = 1'($urandom); d_addr = 10'($urandom_range(15, 0)); d_wdata = $urandom;
      end
      if_req = pf; d_req = pd;
      if (!pf && !pd) begin tick(); continue; end
      gd = arb_data(pf, pd);
      model_grant(pf, gd);
      wait_ack(k, acks, en_cnt, en_at, en_addr, en_we, en_wdata, idle_cyc);
      n_cmp++;
      if ({acks, 8'(k), 4'(en_cnt)} !== {(gd ? 2'b01 : 2'b10), 8'(LAT+2), 4'd1}) begin
        n_bad++;
        $display("FAIL random_grant t=%0d: got ack=%b k=%0d en=%0d want ack=%b k=%0d en=1", t, acks, k, en_cnt, gd ? 2'b01 : 2'b10, LAT+2);
      end
      if (gd) begin
        if (d_we) ref_mem[d_addr] = d_wdata; else ref_drdata = ref_mem[d_addr];
        n_cmp++;
        if (d_rdata !== ref_drdata) begin
          n_bad++; $display("FAIL random_data t=%0d: got %h want %h", t, d_rdata, ref_drdata);
        end
        pd = 0;
      end else begin
        w = if_addr[AW+1:2];
        exp_h = if_addr[1] ? ref_mem[w][31:16] : ref_mem[w][15:0];
        n_cmp++;
        if (if_data !== exp_h) begin
          n_bad++; $display("FAIL random_fetch t=%0d: got %h want %h", t, if_data, exp_h);
        end
        pf = 0;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = seed_word(i);
    reset = 1'b1; mem_init = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    tick();
    mem_init = 1'b0;
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
